// File: rtl/ultrasonido_pkg.sv
// Shared state type, default timing and microsecond-to-cycle conversion for the HC-SR04 ping controller.
// The defaults are also used by the echo-distance counter bench.
package ultrasonido_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        TRIG,
        WAIT_HI,
        MEAS,
        HOLD
    } ping_state_t;

    localparam int DEF_CLK_FREQ_HZ   = 1_000_000;
    localparam int DEF_TRIG_US       = 10;
    localparam int DEF_ECHO_START_US = 30_000;
    localparam int DEF_ECHO_MAX_US   = 38_000;
    localparam int DEF_HOLDOFF_US    = 60_000;

    // 64-bit product: long holdoff windows at fast clocks overflow 32 bits.
    function automatic int us_to_cyc(input int us, input int clk_hz);
        longint cyc;
        cyc = (longint'(us) * longint'(clk_hz)) / 64'sd1_000_000;
        if (cyc < 64'sd1) begin
            cyc = 64'sd1;
        end
        return int'(cyc);
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ultra_echo_sync.sv
// Two-flop synchronizer for the raw sensor echo, plus rise/fall flags of the synchronized level.
module ultra_echo_sync (
    input  logic Varclock,
    input  logic Reset,
    input  logic echo_i,
    output logic echo_s_o,
    output logic echo_rise_o,
    output logic echo_fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge Varclock) begin
        if (!Reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= echo_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign echo_s_o    = sync_q;
    assign echo_rise_o = sync_q & ~prev_q;
    assign echo_fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonido_ping_ctrl.sv
// HC-SR04 initiator: trigger pulse, echo window timing, clear/enable of the distance counter.
// Build option ULTRA_AUTO_RETRIGGER_EN: HOLD re-enters CLR for continuous ranging instead of IDLE.
//
//   state   | meaning
//   IDLE    | waiting for Start
//   CLR     | one-cycle clear of the distance counter
//   TRIG    | trigger pin high for TRIG_CYC cycles
//   WAIT_HI | counter enabled, waiting for echo rise
//   MEAS    | counter enabled, echo high, waiting for fall
//   HOLD    | sensor quiet time before the next ping
module ultrasonido_ping_ctrl
    import ultrasonido_pkg::*;
#(
    parameter int CLK_FREQ_HZ   = DEF_CLK_FREQ_HZ,
    parameter int TRIG_US       = DEF_TRIG_US,
    parameter int ECHO_START_US = DEF_ECHO_START_US,
    parameter int ECHO_MAX_US   = DEF_ECHO_MAX_US,
    parameter int HOLDOFF_US    = DEF_HOLDOFF_US
) (
    input  logic Varclock,
    input  logic Reset,
    input  logic Start,
    input  logic Echo,
    output logic Trigger,
    output logic Clear,
    output logic Enable,
    output logic Busy,
    output logic Valid,
    output logic Timeout
);

    localparam int TRIG_CYC       = us_to_cyc(TRIG_US, CLK_FREQ_HZ);
    localparam int ECHO_START_CYC = us_to_cyc(ECHO_START_US, CLK_FREQ_HZ);
    localparam int ECHO_MAX_CYC   = us_to_cyc(ECHO_MAX_US, CLK_FREQ_HZ);
    localparam int HOLDOFF_CYC    = us_to_cyc(HOLDOFF_US, CLK_FREQ_HZ);
    localparam int MAX_CYC        = max2(max2(TRIG_CYC, ECHO_START_CYC),
                                         max2(ECHO_MAX_CYC, HOLDOFF_CYC));
    localparam int TIMER_W        = $clog2(MAX_CYC) + 1;

    // Loaded with N-1 so that each state lasts exactly N cycles including the exit cycle.
    localparam logic [TIMER_W-1:0] TRIG_LD       = TIMER_W'(TRIG_CYC - 1);
    localparam logic [TIMER_W-1:0] ECHO_START_LD = TIMER_W'(ECHO_START_CYC - 1);
    localparam logic [TIMER_W-1:0] ECHO_MAX_LD   = TIMER_W'(ECHO_MAX_CYC - 1);
    localparam logic [TIMER_W-1:0] HOLDOFF_LD    = TIMER_W'(HOLDOFF_CYC - 1);
    localparam logic [TIMER_W-1:0] TIMER_ONE     = TIMER_W'(1);

    ping_state_t        state_q;
    logic [TIMER_W-1:0] timer_q;
    logic               trigger_q;
    logic               clear_q;
    logic               enable_q;
    logic               busy_q;
    logic               valid_q;
    logic               timeout_q;

    logic echo_s;
    logic echo_fall;
    logic echo_rise_unused;
    logic timer_zero;

    ultra_echo_sync u_echo_sync (
        .Varclock    (Varclock),
        .Reset       (Reset),
        .echo_i      (Echo),
        .echo_s_o    (echo_s),
        .echo_rise_o (echo_rise_unused),
        .echo_fall_o (echo_fall)
    );

    assign timer_zero = (timer_q == '0);

    always_ff @(posedge Varclock) begin
        if (!Reset) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            trigger_q <= 1'b0;
            clear_q   <= 1'b0;
            enable_q  <= 1'b0;
            busy_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            clear_q   <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        state_q <= CLR;
                        clear_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                CLR: begin
                    state_q   <= TRIG;
                    trigger_q <= 1'b1;
                    timer_q   <= TRIG_LD;
                end
                TRIG: begin
                    if (timer_zero) begin
                        state_q   <= WAIT_HI;
                        trigger_q <= 1'b0;
                        enable_q  <= 1'b1;
                        timer_q   <= ECHO_START_LD;
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
                WAIT_HI: begin
                    // Level test, so an echo already high on entry counts as a rise.
                    if (echo_s) begin
                        state_q <= MEAS;
                        timer_q <= ECHO_MAX_LD;
                    end else if (timer_zero) begin
                        state_q   <= HOLD;
                        enable_q  <= 1'b0;
                        timeout_q <= 1'b1;
                        timer_q   <= HOLDOFF_LD;
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
                MEAS: begin
                    if (echo_fall) begin
                        state_q  <= HOLD;
                        enable_q <= 1'b0;
                        valid_q  <= 1'b1;
                        timer_q  <= HOLDOFF_LD;
                    end else if (timer_zero) begin
                        state_q   <= HOLD;
                        enable_q  <= 1'b0;
                        timeout_q <= 1'b1;
                        timer_q   <= HOLDOFF_LD;
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
                HOLD: begin
                    if (timer_zero) begin
`ifdef ULTRA_AUTO_RETRIGGER_EN
                        state_q <= CLR;
                        clear_q <= 1'b1;
`else
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
`endif
                    end else begin
                        timer_q <= timer_q - TIMER_ONE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    timer_q   <= '0;
                    trigger_q <= 1'b0;
                    enable_q  <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign Trigger = trigger_q;
    assign Clear   = clear_q;
    assign Enable  = enable_q;
    assign Busy    = busy_q;
    assign Valid   = valid_q;
    assign Timeout = timeout_q;

endmodule

// File: tb/tb_ultrasonido_ping_ctrl.sv
// Bench for ultrasonido_ping_ctrl: per-cycle output compare against an event-time model of each ping.
// Timing is scaled down (2 MHz clock, short windows) to keep the run short.
module tb_ultrasonido_ping_ctrl;

`ifdef ULTRA_AUTO_RETRIGGER_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    // Hand-derived cycle counts for the parameters below at 2 MHz.
    localparam int T_CYC = 10;
    localparam int E_CYC = 1500;
    localparam int M_CYC = 1900;
    localparam int H_CYC = 600;

    logic Varclock = 1'b0;
    logic Reset;
    logic Start;
    logic Echo;
    logic Trigger;
    logic Clear;
    logic Enable;
    logic Busy;
    logic Valid;
    logic Timeout;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    bit armed   = 1'b0;

    ultrasonido_ping_ctrl #(
        .CLK_FREQ_HZ   (2_000_000),
        .TRIG_US       (5),
        .ECHO_START_US (750),
        .ECHO_MAX_US   (950),
        .HOLDOFF_US    (300)
    ) dut (
        .Varclock (Varclock),
        .Reset    (Reset),
        .Start    (Start),
        .Echo     (Echo),
        .Trigger  (Trigger),
        .Clear    (Clear),
        .Enable   (Enable),
        .Busy     (Busy),
        .Valid    (Valid),
        .Timeout  (Timeout)
    );

    always #5 Varclock = ~Varclock;

    always @(posedge Varclock) cyc <= cyc + 1;

    function automatic logic lvl(input int c, input int r, input int w);
        return (w > 0) && (c >= r) && (c <= r + w - 1);
    endfunction

    task automatic check(input string tag, input int c, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {Trigger, Clear, Enable, Busy, Valid, Timeout};
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b (Trig,Clr,En,Busy,Val,Tmo)",
                   tag, c, obs, exp);
        end
    endtask

    task automatic idle_gap(input int n, input bit noise);
        if (AUTO && armed) return;
        for (int i = 0; i < n; i++) begin
            Start = 1'b0;
            Echo  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge Varclock);
            check("idle", cyc, 6'b0);
        end
        Echo = 1'b0;
    endtask

    // Echo first sampled high d cycles after Trigger falls (d<0: already high), for w cycles (w=0: none).
    task automatic run_ping(input string tag, input int d, input int w, input bit noise,
                            input int rst_after);
        int k, tf, r, meas, fin, last, c;
        bit has_meas, is_valid, drv;
        logic [5:0] exp;
        drv      = !(AUTO && armed);
        k        = cyc + 1;
        tf       = k + T_CYC + 1;
        r        = tf + d;
        meas     = (r + 2 > tf + 1) ? r + 2 : tf + 1;
        has_meas = (w > 0) && (meas <= tf + E_CYC) && (meas - 2 <= r + w - 1);
        if (!has_meas) begin
            fin = tf + E_CYC;
            is_valid = 1'b0;
        end else if (r + w + 2 <= meas + M_CYC) begin
            fin = r + w + 2;
            is_valid = 1'b1;
        end else begin
            fin = meas + M_CYC;
            is_valid = 1'b0;
        end
        last  = AUTO ? fin + H_CYC - 1 : fin + H_CYC;
        Start = drv;
        Echo  = lvl(k, r, w);
        armed = 1'b1;
        forever begin
            @(negedge Varclock);
            c = cyc;
            exp = {(c >= k + 1) && (c <= k + T_CYC),
                   c == k,
                   (c >= tf) && (c < fin),
                   (c >= k) && (AUTO || (c < fin + H_CYC)),
                   (c == fin) && is_valid,
                   (c == fin) && !is_valid};
            check(tag, c, exp);
            if (rst_after >= 0 && has_meas && c == meas + rst_after) begin
                Reset = 1'b0;
                Start = 1'b0;
                Echo  = 1'b0;
                @(negedge Varclock);
                check({tag, "-rst"}, cyc, 6'b0);
                Reset = 1'b1;
                armed = 1'b0;
                return;
            end
            if (c >= last) begin
                Start = 1'b0;
                Echo  = 1'b0;
                return;
            end
            if (noise && (((c >= k + 1) && (c <= k + T_CYC)) ||
                          ((c >= fin) && (c <= fin + H_CYC - 2))))
                Start = 1'($urandom_range(0, 1));
            else
                Start = 1'b0;
            if (noise && (c + 1 >= fin + 1) && (c + 1 <= fin + H_CYC - 5))
                Echo = 1'($urandom_range(0, 1));
            else
                Echo = lvl(c + 1, r, w);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d, w;
        Reset = 1'b0;
        Start = 1'b1;
        Echo  = 1'b1;
        repeat (3) begin
            @(negedge Varclock);
            check("reset", cyc, 6'b0);
        end
        Reset = 1'b1;
        Start = 1'b0;
        Echo  = 1'b0;
        idle_gap(4, 1'b0);

        run_ping("normal", 500, 580, 1'b0, -1);
        idle_gap(3, 1'b0);
        run_ping("no_echo", 0, 0, 1'b0, -1);
        idle_gap(3, 1'b1);
        run_ping("stuck_echo", 100, 2500, 1'b0, -1);
        idle_gap(2, 1'b0);
        run_ping("fall_at_expiry", 300, M_CYC, 1'b0, -1);
        run_ping("one_past_expiry", 300, M_CYC + 1, 1'b0, -1);
        idle_gap(2, 1'b1);
        run_ping("rise_last_wait", E_CYC - 2, 50, 1'b0, -1);
        run_ping("rise_too_late", E_CYC - 1, 50, 1'b0, -1);
        idle_gap(2, 1'b0);
        run_ping("stale_echo", -5, 40, 1'b0, -1);
        run_ping("start_while_busy", 200, 300, 1'b1, -1);
        idle_gap(2, 1'b0);
        run_ping("mid_meas", 400, 900, 1'b0, 50);
        idle_gap(2, 1'b0);
        run_ping("after_reset", 150, 200, 1'b0, -1);
        run_ping("short_echo", 20, 1, 1'b0, -1);

        for (int i = 0; i < 5; i++) begin
            d = int'($urandom_range(0, 1200));
            w = int'($urandom_range(1, 2000));
            idle_gap(int'($urandom_range(1, 6)), 1'b1);
            run_ping("random", d, w, 1'b1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
